// File: rtl/bcd_tick_counter.sv
// Multi-digit BCD event/time counter with a prescaled tick, preload, and a saturate or wrap overflow policy.
// Latency: Load is visible 1 cycle later, and the first tick comes TICK_DIV enabled cycles after a zero prescaler; there is no backpressure, and Enable=0 freezes state.
module bcd_tick_counter #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000,
    parameter int SATURATE = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Clear,
    input  logic                  Enable,
    input  logic                  Load,
    input  logic [4*DIGITS-1:0]   LoadValue,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  Tick,
    output logic                  Overflow,
    output logic                  AllNines
);

    localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]          r_presc;
    logic [4*DIGITS-1:0]    r_bcd;
    logic                   r_tick;
    logic                   r_ovf;

    logic                   w_tick_now;
    logic [DIGITS-1:0]      w_is_nine;
    logic [4*DIGITS-1:0]    w_inc_bcd;
    logic [4*DIGITS-1:0]    w_next_bcd;
    logic [4*DIGITS-1:0]    w_load_bcd;

    assign w_tick_now = Enable && (r_presc == PRESC_MAX);

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            assign w_is_nine[g] = (r_bcd[4*g +: 4] == 4'd9);
            // Out-of-range preload digits are pinned to 9 so digits never leave 0..9.
            assign w_load_bcd[4*g +: 4] = (LoadValue[4*g +: 4] > 4'd9) ? 4'd9 : LoadValue[4*g +: 4];
        end
    endgenerate

    always_comb begin : incr
        logic w_carry;
        w_inc_bcd = r_bcd;
        w_carry   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_carry) begin
                w_inc_bcd[4*i +: 4] = w_is_nine[i] ? 4'd0 : r_bcd[4*i +: 4] + 4'd1;
            end
            w_carry = w_carry && w_is_nine[i];
        end
    end

    // A plain increment of all-nines already rolls over to zero, so only saturation needs a hold.
    assign w_next_bcd = (AllNines && (SATURATE != 0)) ? r_bcd : w_inc_bcd;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_presc <= '0;
            r_bcd   <= '0;
            r_tick  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (Clear) begin
            r_presc <= '0;
            r_bcd   <= '0;
            r_tick  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (Load) begin
            r_presc <= '0;
            r_bcd   <= w_load_bcd;
            r_tick  <= 1'b0;
        end else if (w_tick_now) begin
            r_presc <= '0;
            r_bcd   <= w_next_bcd;
            r_tick  <= 1'b1;
            if (AllNines) begin
                r_ovf <= 1'b1;
            end
        end else begin
            r_tick <= 1'b0;
            if (Enable) begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign BCD      = r_bcd;
    assign Tick     = r_tick;
    assign Overflow = r_ovf;
    assign AllNines = &w_is_nine;

endmodule
